byte_joiner: RTL and testbench
==============================

// Module: byte_joiner
//
// PURPOSE
// - Concatenates two half-words into one full word: o = {high, low}.
// - Used in the 3-stage CPU datapath to build 16-bit values from byte sources:
//   immediate high/low bytes, memory byte pairs, and address formation.
// - Provides a combinational output and a one-cycle registered copy for
//   pipeline-stage alignment.
//
// PARAMETERS
// - HALF_W  8   width of each input half; output width is 2*HALF_W.
//
// PORTS
// - clk   input   1         single clock, rising-edge.
// - rst   input   1         synchronous, active-high reset.
// - low   input   HALF_W    least-significant half.
// - high  input   HALF_W    most-significant half.
// - o     output  2*HALF_W  combinational concatenation {high, low}.
// - o_q   output  2*HALF_W  registered copy of o, updated every clk edge.
//
// BEHAVIOUR
// - o[HALF_W-1:0] = low.
// - o[2*HALF_W-1:HALF_W] = high.
// - Output o:
//   - Purely combinational, with zero latency.
//   - Does not depend on clk or rst; it is valid with no clock running.
// - Output o_q:
//   - On each rising clk edge with rst=1: o_q <= 0. rst has priority.
//   - On each rising clk edge with rst=0: o_q <= {high, low}.
//   - Latency is one cycle. There is no enable; o_q loads every cycle.
// - Reset values:
//   - o_q = 0 after reset.
//   - o has no reset value; it always tracks its inputs.
// - Width and bit rules:
//   - No arithmetic, sign extension, or byte swapping.
//   - Bits pass through in position.
// - X/Z on an input propagates only into the corresponding half of o and o_q.
//   It does not corrupt the other half.
// - Reset asserted mid-stream: o_q clears on that edge. o keeps following the
//   inputs.
// - rst deassert: o_q captures the current {high, low} on the first edge with
//   rst=0.
//
// STRUCTURE
// - Shared CPU package holds:
//   - localparam BYTE_W = 8.
//   - localparam WORD_W = 16.
//   - typedef logic [BYTE_W-1:0] byte_t.
//   - typedef logic [WORD_W-1:0] word_t.
// - No sub-module: one continuous assign plus one always block.
//
// TESTING
// - Combinational, no clock: low=8'hFF, high=8'h00 -> o=16'h00FF.
//   After 100 ns set low=8'h00, high=8'hFF -> o=16'hFF00 with no delta lag.
// - Reset: rst=1 for 2 edges with low=8'hAA, high=8'h55 -> o_q=16'h0000
//   while o=16'h55AA.
// - Pipeline: rst=0; apply low=8'h34, high=8'h12 before edge N.
//   -> o_q=16'h1234 after edge N, not before.
// - Back-to-back: new {high, low} each cycle (16'h0001, 16'h8000, 16'hFFFF)
//   -> o_q follows one cycle behind with no skipped values.
// - Mid-stream reset: rst=1 for one edge while inputs are 16'hBEEF
//   -> o_q=16'h0000 that cycle; 16'hBEEF on the next edge after rst=0.
// - Independence: walk a single 1 through all 16 bit positions
//   -> the bit appears only at the matching position of o and o_q.

Source files
------------

// File: rtl/byte_joiner_pkg.sv
// Shared CPU datapath widths and types for building 16-bit words from byte sources.
package byte_joiner_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

endpackage : byte_joiner_pkg

// File: rtl/byte_joiner.sv
// Joins a high and low half into one word; combinational result plus a
// one-cycle registered copy for pipeline-stage alignment.
module byte_joiner
    import byte_joiner_pkg::*;
#(
    parameter int HALF_W = BYTE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HALF_W-1:0]     low,
    input  logic [HALF_W-1:0]     high,
    output logic [2*HALF_W-1:0]   o,
    output logic [2*HALF_W-1:0]   o_q
);

    // Bits pass straight through in position; no arithmetic or swapping.
    assign o = {high, low};

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else begin
            o_q <= o;
        end
    end

endmodule : byte_joiner

// File: tb/tb_byte_joiner.sv
// Directed self-checking bench for byte_joiner: combinational path, reset,
// pipeline latency, back-to-back streaming, mid-stream reset and bit isolation.
module tb_byte_joiner;
    import byte_joiner_pkg::*;

    logic  clk;
    logic  clkEnable;
    logic  rst;
    byte_t low;
    byte_t high;
    word_t o;
    word_t oQ;

    int vectors;
    int miscompares;

    byte_joiner #(.HALF_W(BYTE_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .low  (low),
        .high (high),
        .o    (o),
        .o_q  (oQ)
    );

    // Clock is held low until the combinational checks have run with no clock.
    initial clk = 1'b0;
    always #5 if (clkEnable) clk = ~clk;

    task automatic applyStimulus(input byte_t highVal, input byte_t lowVal, input logic rstVal);
        high = highVal;
        low  = lowVal;
        rst  = rstVal;
    endtask

    task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        word_t walkWord;
        vectors     = 0;
        miscompares = 0;
        clkEnable   = 1'b0;
        applyStimulus(8'h00, 8'hFF, 1'b0);

        #1;
        checkOutput("comb_00FF", o, 16'h00FF);
        #100;
        applyStimulus(8'hFF, 8'h00, 1'b0);
        #1;
        checkOutput("comb_FF00", o, 16'hFF00);

        applyStimulus(8'h55, 8'hAA, 1'b1);
        #1;
        clkEnable = 1'b1;
        tick();
        checkOutput("reset1_oq", oQ, 16'h0000);
        checkOutput("reset1_o", o, 16'h55AA);
        tick();
        checkOutput("reset2_oq", oQ, 16'h0000);
        checkOutput("reset2_o", o, 16'h55AA);

        applyStimulus(8'h12, 8'h34, 1'b0);
        #1;
        checkOutput("pipe_before", oQ, 16'h0000);
        checkOutput("pipe_comb", o, 16'h1234);
        tick();
        checkOutput("pipe_after", oQ, 16'h1234);

        applyStimulus(8'h00, 8'h01, 1'b0);
        #1;
        checkOutput("b2b_hold", oQ, 16'h1234);
        tick();
        checkOutput("b2b_0001", oQ, 16'h0001);
        applyStimulus(8'h80, 8'h00, 1'b0);
        tick();
        checkOutput("b2b_8000", oQ, 16'h8000);
        applyStimulus(8'hFF, 8'hFF, 1'b0);
        tick();
        checkOutput("b2b_FFFF", oQ, 16'hFFFF);

        applyStimulus(8'hBE, 8'hEF, 1'b1);
        tick();
        checkOutput("midrst_oq", oQ, 16'h0000);
        checkOutput("midrst_o", o, 16'hBEEF);
        applyStimulus(8'hBE, 8'hEF, 1'b0);
        tick();
        checkOutput("midrst_release", oQ, 16'hBEEF);

        // An unknown low half must not leak into the high half.
        applyStimulus(8'h12, 8'hxx, 1'b0);
        #1;
        checkOutput("xlow_o", o, 16'h12xx);
        tick();
        checkOutput("xlow_oq", oQ, 16'h12xx);

        for (int i = 0; i < WORD_W; i++) begin
            walkWord = word_t'(1) << i;
            applyStimulus(walkWord[15:8], walkWord[7:0], 1'b0);
            #1;
            checkOutput($sformatf("walk_o_%0d", i), o, walkWord);
            tick();
            checkOutput($sformatf("walk_oq_%0d", i), oQ, walkWord);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_byte_joiner
